// File: rtl/screen_scan_driver.sv
// Scans one of NUM_SCREENS stored monochrome bitmaps out to a two-half RGB LED
// panel (serial shift, blank, latch, hold per row pair). Screen changes are
// adopted only at the start of a frame so the panel never shows a torn image.
// The bitmap image is supplied through ROM_INIT: word w = screen*ROWS + row sits
// at ROM_INIT[w*COLS +: COLS], and bit COLS-1 of a word is column 0.
module screen_scan_driver #(
    parameter int         NUM_SCREENS = 16,
    parameter int         ROWS        = 32,
    parameter int         COLS        = 16,
    parameter int         HOLD_CYCLES = 64,
    parameter logic [2:0] PIXEL_RGB   = 3'b100,
    parameter int         BORDER_EN   = 1,
    parameter logic [2:0] BORDER_RGB  = 3'b010,
    parameter logic [NUM_SCREENS*ROWS*COLS-1:0] ROM_INIT = '0,
    localparam int SW = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1,
    localparam int RW = (ROWS > 2) ? $clog2(ROWS / 2) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [SW-1:0] screen_req,
    input  logic          screen_req_valid,
    input  logic          blank,
    output logic          screen_ack,
    output logic [SW-1:0] cur_screen,
    output logic          frame_start,
    output logic [5:0]    rgb,
    output logic          sclk,
    output logic          lat,
    output logic          oe_n,
    output logic [RW-1:0] row_addr
);

    localparam int HALF    = ROWS / 2;
    localparam int DEPTH   = NUM_SCREENS * ROWS;
    localparam int AW      = $clog2(DEPTH);
    localparam int CLW     = $clog2(COLS);
    localparam int CNT_MAX = (2 * COLS > HOLD_CYCLES) ? 2 * COLS : HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   pair_q, pair_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   cur_screen_q, cur_screen_d;
    logic [SW-1:0]   pend_q, pend_d;
    logic            pend_valid_q, pend_valid_d;
    logic            shown_q, shown_d;
    logic [COLS-1:0] rom_top_q, rom_top_d;
    logic [COLS-1:0] rom_bot_q, rom_bot_d;
    logic [5:0]      rgb_q, rgb_d;
    logic            sclk_q, sclk_d;
    logic            lat_q, lat_d;
    logic            oe_n_q, oe_n_d;
    logic [RW-1:0]   row_addr_q, row_addr_d;
    logic            ack_q, ack_d;
    logic            fs_q, fs_d;

    // Bitmap store as a word array, one row of one screen per word
    logic [COLS-1:0] rom [DEPTH];
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom[gi] = ROM_INIT[gi*COLS +: COLS];
    end

    logic            adopt;
    logic            req_ok;
    logic [SW-1:0]   screen_sel;
    logic [AW-1:0]   addr_top, addr_bot;
    logic [CLW-1:0]  col;
    logic            phase_b;
    logic            col_edge, top_border, bot_border;
    logic [2:0]      top_pix, bot_pix;

    // Adoption happens in FETCH of pair 0, and that fetch must already read the new screen
    assign adopt      = (state_q == ST_FETCH) && (pair_q == '0) && pend_valid_q;
    assign req_ok     = screen_req_valid && (32'(screen_req) < NUM_SCREENS);
    assign screen_sel = adopt ? pend_q : cur_screen_q;
    assign addr_top   = AW'(int'(screen_sel) * ROWS + int'(pair_q));
    assign addr_bot   = AW'(int'(screen_sel) * ROWS + int'(pair_q) + HALF);

    // In SHIFT the counter's LSB selects the data/clock half, the rest is the column
    assign col        = cnt_q[CLW:1];
    assign phase_b    = cnt_q[0];
    assign col_edge   = (col == '0) || (col == CLW'(COLS - 1));
    assign top_border = (BORDER_EN != 0) && ((pair_q == '0) || col_edge);
    assign bot_border = (BORDER_EN != 0) && ((pair_q == RW'(HALF - 1)) || col_edge);
    assign top_pix    = top_border ? BORDER_RGB :
                        (rom_top_q[CLW'(COLS - 1) - col] ? PIXEL_RGB : 3'b000);
    assign bot_pix    = bot_border ? BORDER_RGB :
                        (rom_bot_q[CLW'(COLS - 1) - col] ? PIXEL_RGB : 3'b000);

    // Next-state, request bookkeeping and the registered panel outputs for each state
    always_comb begin
        state_d      = state_q;
        pair_d       = pair_q;
        cnt_d        = cnt_q;
        cur_screen_d = cur_screen_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        shown_d      = shown_q;
        rom_top_d    = rom_top_q;
        rom_bot_d    = rom_bot_q;
        rgb_d        = '0;
        sclk_d       = 1'b0;
        lat_d        = 1'b0;
        oe_n_d       = ~shown_q;
        row_addr_d   = row_addr_q;
        ack_d        = 1'b0;
        fs_d         = 1'b0;

        if (adopt) begin
            cur_screen_d = pend_q;
            pend_valid_d = 1'b0;
            ack_d        = 1'b1;
        end
        // A request arriving in the adoption cycle becomes the next pending one
        if (req_ok) begin
            pend_d       = screen_req;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            ST_FETCH: begin
                rom_top_d = rom[addr_top];
                rom_bot_d = rom[addr_bot];
                fs_d      = (pair_q == '0);
                cnt_d     = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!phase_b) begin
                    rgb_d = blank ? 6'b000000 : {top_pix, bot_pix};
                end else begin
                    rgb_d  = rgb_q;
                    sclk_d = 1'b1;
                end
                if (cnt_q == CW'(2 * COLS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_BLANK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BLANK: begin
                oe_n_d  = 1'b1;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                lat_d      = 1'b1;
                oe_n_d     = 1'b1;
                row_addr_d = pair_q;
                shown_d    = 1'b1;
                cnt_d      = '0;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                oe_n_d = 1'b0;
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    cnt_d   = '0;
                    pair_d  = (pair_q == RW'(HALF - 1)) ? '0 : pair_q + RW'(1);
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and output registers; reset also drops any pending request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_FETCH;
            pair_q       <= '0;
            cnt_q        <= '0;
            cur_screen_q <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            shown_q      <= 1'b0;
            rom_top_q    <= '0;
            rom_bot_q    <= '0;
            rgb_q        <= '0;
            sclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            row_addr_q   <= '0;
            ack_q        <= 1'b0;
            fs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pair_q       <= pair_d;
            cnt_q        <= cnt_d;
            cur_screen_q <= cur_screen_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            shown_q      <= shown_d;
            rom_top_q    <= rom_top_d;
            rom_bot_q    <= rom_bot_d;
            rgb_q        <= rgb_d;
            sclk_q       <= sclk_d;
            lat_q        <= lat_d;
            oe_n_q       <= oe_n_d;
            row_addr_q   <= row_addr_d;
            ack_q        <= ack_d;
            fs_q         <= fs_d;
        end
    end

    assign screen_ack  = ack_q;
    assign cur_screen  = cur_screen_q;
    assign frame_start = fs_q;
    assign rgb         = rgb_q;
    assign sclk        = sclk_q;
    assign lat         = lat_q;
    assign oe_n        = oe_n_q;
    assign row_addr    = row_addr_q;

endmodule
